fp_max_finder: RTL
==================

Name: fp_max_finder

Overview:
- Streaming reduction stage that consumes the team's 13-bit floating-point format: 1 sign bit, 4-bit exponent, 8-bit normalized fraction.
- Accepts a frame of N samples over a valid/ready handshake and reports the largest signed value and its index within the frame.
- Sits directly downstream of the fp_gt comparator and instantiates it as its decision element.
- Feeds the sorting and peak-detect logic in the FP datapath.

Parameters:
- N, 8, samples per frame; legal range is 1..2**IW.
- IW, 3, index/counter width; must satisfy 2**IW >= N.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begins a new frame; sampled only in IDLE or DONE.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- sign_in  in  1  sample sign.
- exp_in  in  4  sample exponent.
- frac_in  in  8  sample fraction.
- max_sign  out  1  sign of frame maximum.
- max_exp  out  4  exponent of frame maximum.
- max_frac  out  8  fraction of frame maximum.
- max_idx  out  IW  index (0-based) of the maximum within the frame.
- busy  out  1  high in RUN.
- done_tick  out  1  one-cycle pulse when the result is valid.

Behaviour:
- Reset (async, active-high): state=IDLE; all outputs 0, including in_ready, busy, done_tick, max_* and max_idx; count=0.
- FSM states:
  - IDLE: start=1 -> RUN. On that edge, count and max_* are cleared.
  - RUN: in_ready=1 and busy=1. A transfer occurs when in_valid and in_ready are both high at a rising edge.
    - Transfer with count==0: load the sample into max_* unconditionally and set max_idx=0.
    - Transfer with count>0: replace max_* and set max_idx=count only if fp_gt(sample, current max)=1. Strictly greater, so ties keep the earlier index.
    - count increments on each transfer.
    - Transfer with count==N-1: go to DONE.
  - DONE: done_tick=1 for exactly this one cycle; in_ready=0; busy=0. Next state is RUN if start=1 in this cycle, else IDLE.
- Latency: done_tick is high in the cycle immediately after the edge that accepted the Nth sample. Minimum frame time is N+1 cycles from entering RUN.
- max_* and max_idx hold their last frame result in IDLE until the next start. They are not cleared by start until the RUN entry edge.
- start during RUN is ignored. in_valid outside RUN is ignored (in_ready=0).
- Comparison semantics come from fp_gt: magnitude is compared on {exp,frac}; sign decides the ordering. +0 and -0 compare equal, so the earlier one is kept.
- N=1: the first transfer goes straight to DONE, and max_idx=0.
- count is IW bits and never wraps within a frame, because it terminates at N-1.
- Reset asserted mid-frame: the partial frame is discarded, there is no done_tick, and the block returns to IDLE with outputs zeroed.
- All outputs are registered except in_ready and busy, which are decoded from the state register.

Decomposition:
- Shared package: FP field widths (EXP_W=4, FRAC_W=8) and FSM state encodings (IDLE, RUN, DONE).
- Sub-module: one instance of the existing fp_gt comparator. Inputs are the sample and the current max register; its gt output drives the replace enable.
- Everything else (FSM, counter, max registers) stays in a single module of about 150–200 lines.

Test Plan:
- Reset, start, N=8 samples with increasing magnitude (exp=1..8, frac=0x80, sign=0), in_valid held high -> done_tick 9 cycles after RUN entry; max={0,8,0x80}; max_idx=7.
- Mixed signs: -3.0, +0.5, -8.0, +2.0, then four copies of -1.0 -> max equals the +2.0 encoding, max_idx=3.
- All eight samples equal {1,3,0xC0} -> max is that value and max_idx=0 (tie keeps first). Repeat with +0/-0 alternating -> max_idx=0.
- in_valid toggled randomly with 50% gaps -> result matches the gap-free run; done_tick occurs exactly one cycle after the 8th transfer; start pulses during RUN have no effect.
- Reset asserted after 4 transfers -> no done_tick; all outputs 0; in_ready=0. A new start then completes a clean frame.
- start held high through DONE -> back-to-back frames with no IDLE cycle; results of frame 2 are independent of frame 1. N=1 build returns the single sample with max_idx=0.

Source files
------------

// File: rtl/fp_max_finder_pkg.sv
// Shared definitions for the 13-bit FP max-finder slice.
// Field widths and the reduction FSM encoding.
package fp_max_finder_pkg;

  localparam int EXP_W  = 4;
  localparam int FRAC_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp_gt.sv
// Signed greater-than for the 13-bit FP format.
// Magnitude is {exp,frac}; +0 and -0 compare equal.
module fp_gt
  import fp_max_finder_pkg::*;
(
  input  logic              a_sign,
  input  logic [EXP_W-1:0]  a_exp,
  input  logic [FRAC_W-1:0] a_frac,
  input  logic              b_sign,
  input  logic [EXP_W-1:0]  b_exp,
  input  logic [FRAC_W-1:0] b_frac,
  output logic              gt
);

  logic [EXP_W+FRAC_W-1:0] a_mag;
  logic [EXP_W+FRAC_W-1:0] b_mag;
  logic                    both_zero;

  assign a_mag     = {a_exp, a_frac};
  assign b_mag     = {b_exp, b_frac};
  assign both_zero = (a_mag == '0) && (b_mag == '0);

  always_comb begin
    gt = 1'b0;
    if (a_sign != b_sign)
      gt = !a_sign && !both_zero;
    else if (!a_sign)
      gt = a_mag > b_mag;
    else
      gt = a_mag < b_mag;
  end

endmodule

// File: rtl/fp_max_finder.sv
// Streaming frame reduction: largest signed sample and its index.
// Ties keep the earliest index.
module fp_max_finder
  import fp_max_finder_pkg::*;
#(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [FRAC_W-1:0] frac_in,
  output logic              max_sign,
  output logic [EXP_W-1:0]  max_exp,
  output logic [FRAC_W-1:0] max_frac,
  output logic [IW-1:0]     max_idx,
  output logic              busy,
  output logic              done_tick
);

  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t        state_q;
  state_t        state_d;
  logic [IW-1:0] count;
  logic          gt;
  logic          xfer;
  logic          last;
  logic          take;
  logic          enter_run;

  fp_gt u_gt (
    .a_sign (sign_in),
    .a_exp  (exp_in),
    .a_frac (frac_in),
    .b_sign (max_sign),
    .b_exp  (max_exp),
    .b_frac (max_frac),
    .gt     (gt)
  );

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q == RUN);
  assign xfer     = in_valid && in_ready;
  assign last     = (count == LAST);
  assign take     = xfer && ((count == '0) || gt);

  always_comb begin
    state_d   = state_q;
    enter_run = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          enter_run = 1'b1;
        end
      end
      RUN: begin
        if (xfer && last)
          state_d = DONE;
      end
      DONE: begin
        if (start) begin
          state_d   = RUN;
          enter_run = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count     <= '0;
      max_sign  <= 1'b0;
      max_exp   <= '0;
      max_frac  <= '0;
      max_idx   <= '0;
      done_tick <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_tick <= xfer && last;
      if (enter_run) begin
        count    <= '0;
        max_sign <= 1'b0;
        max_exp  <= '0;
        max_frac <= '0;
        max_idx  <= '0;
      end else if (xfer) begin
        // Counter parks at zero after the last sample, so it never wraps.
        count <= last ? '0 : count + 1'b1;
        if (take) begin
          max_sign <= sign_in;
          max_exp  <= exp_in;
          max_frac <= frac_in;
          max_idx  <= count;
        end
      end
    end
  end

endmodule
